// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive framer.
// The CRC helper is used only when RGMII_RX_FCS_CHECK_EN is defined.
package rgmii_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } rxState_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   // Ethernet shifts LSB first, so the register runs with the bit-reversed polynomial.
   function automatic logic [31:0] crc32Next(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] polyRefl;
      logic [31:0] c;
      for (int i = 0; i < 32; i++) begin
         polyRefl[i] = CRC32_POLY[31-i];
      end
      c = crc ^ {24'h000000, data};
      for (int b = 0; b < 8; b++) begin
         c = c[0] ? ((c >> 1) ^ polyRefl) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/rgmii_crc32.sv
// Byte-wide reflected CRC-32 register; compiled only with RGMII_RX_FCS_CHECK_EN,
// since the framer instantiates it only in that build.
`ifdef RGMII_RX_FCS_CHECK_EN
module rgmii_crc32
   import rgmii_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        update,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         crc <= CRC32_INIT;
      end else if (update) begin
         crc <= crc32Next(crc, data);
      end
   end

endmodule
`endif

// File: rtl/rgmii_rx_framer.sv
// Gigabit RGMII receive framer: byte reassembly, preamble/SFD strip, last/error marking,
// frame counters. Define RGMII_RX_FCS_CHECK_EN to add CRC-32 FCS checking to errOut.
module rgmii_rx_framer
   import rgmii_pkg::*;
#(
   parameter int MIN_FRAME_LEN = 64,
   parameter int MAX_FRAME_LEN = 1518,
   parameter int LEN_W         = 16,
   parameter int CNT_W         = 16
) (
   input  logic             rxClkIn,
   input  logic             rstIn,
   input  logic             enIn,
   input  logic [3:0]       rxDataRiseIn,
   input  logic [3:0]       rxDataFallIn,
   input  logic             rxCtrlRiseIn,
   input  logic             rxCtrlFallIn,
   output logic [7:0]       dataOut,
   output logic             validOut,
   output logic             lastOut,
   output logic             errOut,
   output logic [LEN_W-1:0] frameLenOut,
   output logic             frameDoneOut,
   output logic [CNT_W-1:0] goodFrameCntOut,
   output logic [CNT_W-1:0] badFrameCntOut
);

   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_LEN);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);

   logic [7:0]       inByte;
   logic             inDv;
   logic             inEr;
   logic             inEn;

   rxState_e         state;
   rxState_e         stateNext;

   logic [7:0]       holdByte;
   logic             holdValid;
   logic [LEN_W-1:0] length;
   logic             errFlag;
   logic             crcBad;

   logic             startFrame;
   logic             acceptByte;
   logic             emitByte;
   logic             emitLast;
   logic             frameBad;
   logic             goodInc;
   logic             badInc;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge rxClkIn) begin
      if (rstIn) begin
         inByte <= 8'h00;
         inDv   <= 1'b0;
         inEr   <= 1'b0;
         inEn   <= 1'b0;
      end else begin
         inByte <= {rxDataFallIn, rxDataRiseIn};
         inDv   <= rxCtrlRiseIn & enIn;
         inEr   <= (rxCtrlRiseIn ^ rxCtrlFallIn) & enIn;
         inEn   <= enIn;
      end
   end

`ifdef RGMII_RX_FCS_CHECK_EN
   logic [31:0] crc;

   rgmii_crc32 crcUnit (
      .clk    (rxClkIn),
      .rst    (rstIn),
      .clear  (startFrame),
      .update (acceptByte),
      .data   (inByte),
      .crc    (crc)
   );

   assign crcBad = (crc != CRC32_RESIDUE);
`else
   assign crcBad = 1'b0;
`endif

   always_ff @(posedge rxClkIn) begin
      if (rstIn) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      stateNext  = state;
      startFrame = 1'b0;
      acceptByte = 1'b0;
      emitByte   = 1'b0;
      emitLast   = 1'b0;
      frameBad   = 1'b0;
      badInc     = 1'b0;
      goodInc    = 1'b0;

      unique case (state)
         IDLE: begin
            if (inDv) begin
               if (inByte == PREAMBLE_BYTE) begin
                  stateNext = PREAMBLE;
               end else begin
                  stateNext = DROP;
                  badInc    = 1'b1;
               end
            end
         end
         PREAMBLE: begin
            if (!inDv) begin
               stateNext = IDLE;
            end else if (inByte == SFD_BYTE) begin
               stateNext  = DATA;
               startFrame = 1'b1;
            end else if (inByte != PREAMBLE_BYTE) begin
               stateNext = DROP;
               badInc    = 1'b1;
            end
         end
         DATA: begin
            if (!inDv) begin
               // A deasserted enable masks dv, so treat that ending as a broken frame.
               stateNext = IDLE;
               if (holdValid) begin
                  emitByte = 1'b1;
                  emitLast = 1'b1;
                  frameBad = errFlag | inEr | ~inEn | (length < MIN_LEN) | crcBad;
               end else begin
                  badInc = 1'b1;
               end
            end else if (length >= MAX_LEN) begin
               stateNext = DROP;
               emitByte  = 1'b1;
               emitLast  = 1'b1;
               frameBad  = 1'b1;
            end else begin
               acceptByte = 1'b1;
               emitByte   = holdValid;
            end
         end
         DROP: begin
            if (!inDv) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase

      if (emitLast) begin
         goodInc = ~frameBad;
         badInc  = frameBad;
      end
   end

   always_ff @(posedge rxClkIn) begin
      if (rstIn) begin
         holdByte  <= 8'h00;
         holdValid <= 1'b0;
         length    <= '0;
         errFlag   <= 1'b0;
      end else if (startFrame) begin
         holdValid <= 1'b0;
         length    <= '0;
         errFlag   <= 1'b0;
      end else if (acceptByte) begin
         holdByte  <= inByte;
         holdValid <= 1'b1;
         errFlag   <= errFlag | inEr;
         if (length != '1) begin
            length <= length + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge rxClkIn) begin
      if (rstIn) begin
         dataOut         <= 8'h00;
         validOut        <= 1'b0;
         lastOut         <= 1'b0;
         errOut          <= 1'b0;
         frameDoneOut    <= 1'b0;
         frameLenOut     <= '0;
         goodFrameCntOut <= '0;
         badFrameCntOut  <= '0;
      end else begin
         dataOut      <= emitByte ? holdByte : 8'h00;
         validOut     <= emitByte;
         lastOut      <= emitLast;
         errOut       <= emitLast & frameBad;
         frameDoneOut <= emitLast;
         if (emitLast) begin
            frameLenOut <= length;
         end
         if (goodInc && (goodFrameCntOut != '1)) begin
            goodFrameCntOut <= goodFrameCntOut + CNT_W'(1);
         end
         if (badInc && (badFrameCntOut != '1)) begin
            badFrameCntOut <= badFrameCntOut + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Directed bench for rgmii_rx_framer: stimulus pushes expected beats to a scoreboard
// queue, a negedge monitor pops and compares them, including the 3-edge latency.
`timescale 1ns/1ps
module tb_rgmii_rx_framer;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;
   localparam int LEN_W   = 16;
   localparam int CNT_W   = 16;

`ifdef RGMII_RX_FCS_CHECK_EN
   localparam bit FCS_CHECK = 1'b1;
`else
   localparam bit FCS_CHECK = 1'b0;
`endif

   logic             rxClkIn = 1'b0;
   logic             rstIn;
   logic             enIn;
   logic [3:0]       rxDataRiseIn;
   logic [3:0]       rxDataFallIn;
   logic             rxCtrlRiseIn;
   logic             rxCtrlFallIn;
   logic [7:0]       dataOut;
   logic             validOut;
   logic             lastOut;
   logic             errOut;
   logic [LEN_W-1:0] frameLenOut;
   logic             frameDoneOut;
   logic [CNT_W-1:0] goodFrameCntOut;
   logic [CNT_W-1:0] badFrameCntOut;

   rgmii_rx_framer #(
      .MIN_FRAME_LEN (MIN_LEN),
      .MAX_FRAME_LEN (MAX_LEN),
      .LEN_W         (LEN_W),
      .CNT_W         (CNT_W)
   ) dut (
      .rxClkIn         (rxClkIn),
      .rstIn           (rstIn),
      .enIn            (enIn),
      .rxDataRiseIn    (rxDataRiseIn),
      .rxDataFallIn    (rxDataFallIn),
      .rxCtrlRiseIn    (rxCtrlRiseIn),
      .rxCtrlFallIn    (rxCtrlFallIn),
      .dataOut         (dataOut),
      .validOut        (validOut),
      .lastOut         (lastOut),
      .errOut          (errOut),
      .frameLenOut     (frameLenOut),
      .frameDoneOut    (frameDoneOut),
      .goodFrameCntOut (goodFrameCntOut),
      .badFrameCntOut  (badFrameCntOut)
   );

   always #4 rxClkIn = ~rxClkIn;

   int cyc = 0;
   always @(posedge rxClkIn) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       err;
      int         len;
      int         cyc;
   } expBeat_t;

   expBeat_t   sbQ[$];
   expBeat_t   monBeat;
   logic [7:0] txBuf[$];
   int         checks = 0;
   int         errors = 0;
   int         expGood = 0;
   int         expBad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic driveByte(input logic [7:0] b, input logic dv, input logic er, input logic en);
      @(posedge rxClkIn);
      #1;
      rxDataRiseIn = b[3:0];
      rxDataFallIn = b[7:4];
      rxCtrlRiseIn = dv;
      rxCtrlFallIn = dv ^ er;
      enIn         = en;
   endtask

   task automatic fillRamp(input int n, input logic [7:0] start, input logic [7:0] step);
      logic [7:0] v;
      txBuf.delete();
      v = start;
      for (int i = 0; i < n; i++) begin
         txBuf.push_back(v);
         v = v + step;
      end
   endtask

   // Independent bit-serial reference for the Ethernet FCS.
   function automatic logic [31:0] refFcs(input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h000000, txBuf[i]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   task automatic finishFrame();
      for (int k = 0; k < 100 && sbQ.size() != 0; k++) @(negedge rxClkIn);
      @(negedge rxClkIn);
      check("scoreboardDrained", sbQ.size(), 0);
      check("goodFrameCnt", goodFrameCntOut, expGood);
      check("badFrameCnt", badFrameCntOut, expBad);
   endtask

   task automatic sendFrame(input int erIdx, input int enDropIdx, input bit fcsBad);
      int       n;
      int       nOut;
      logic     bad;
      expBeat_t e;
      n    = txBuf.size();
      nOut = (n > MAX_LEN) ? MAX_LEN : n;
      if (enDropIdx >= 0 && enDropIdx < nOut) nOut = enDropIdx;
      bad = (nOut < MIN_LEN) || (n > MAX_LEN) || (erIdx >= 0 && erIdx < nOut) ||
            (enDropIdx >= 0 && enDropIdx < n) || fcsBad;
      if (bad) expBad++;
      else expGood++;
      repeat (7) driveByte(8'h55, 1'b1, 1'b0, 1'b1);
      driveByte(8'hD5, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) begin
         driveByte(txBuf[i], 1'b1, (i == erIdx), !(enDropIdx >= 0 && i >= enDropIdx));
         if (i < nOut) begin
            e.data = txBuf[i];
            e.last = (i == nOut - 1);
            e.err  = (i == nOut - 1) ? bad : 1'b0;
            e.len  = nOut;
            e.cyc  = cyc + 3;
            sbQ.push_back(e);
         end
      end
      repeat (12) driveByte(8'h00, 1'b0, 1'b0, 1'b1);
      finishFrame();
   endtask

   always @(negedge rxClkIn) begin
      if (validOut === 1'b1) begin
         if (sbQ.size() == 0) begin
            check("unexpectedValid", validOut, 1'b0);
         end else begin
            monBeat = sbQ.pop_front();
            check("data", dataOut, monBeat.data);
            check("latency", cyc, monBeat.cyc);
            check("last", lastOut, monBeat.last);
            check("frameDone", frameDoneOut, monBeat.last);
            check("err", errOut, monBeat.err);
            if (monBeat.last) check("frameLen", frameLenOut, monBeat.len);
         end
      end else if (frameDoneOut !== 1'b0) begin
         check("doneWithoutValid", frameDoneOut, 1'b0);
      end
   end

   initial begin
      #3000000;
      $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rstIn        = 1'b1;
      enIn         = 1'b1;
      rxDataRiseIn = 4'h0;
      rxDataFallIn = 4'h0;
      rxCtrlRiseIn = 1'b0;
      rxCtrlFallIn = 1'b0;
      repeat (3) @(posedge rxClkIn);
      @(negedge rxClkIn);
      check("rstData", dataOut, 8'h00);
      check("rstValid", validOut, 1'b0);
      check("rstLast", lastOut, 1'b0);
      check("rstErr", errOut, 1'b0);
      check("rstLen", frameLenOut, 0);
      check("rstDone", frameDoneOut, 1'b0);
      check("rstGood", goodFrameCntOut, 0);
      check("rstBad", badFrameCntOut, 0);
      @(posedge rxClkIn);
      #1;
      rstIn = 1'b0;
      repeat (4) driveByte(8'h00, 1'b0, 1'b0, 1'b1);

      // 64-byte minimum-size good frame
      fillRamp(64, 8'h00, 8'h01);
      sendFrame(-1, -1, 1'b0);

      // runt: 60 bytes
      fillRamp(60, 8'h00, 8'h01);
      sendFrame(-1, -1, 1'b0);

      // receive error on the 10th byte of a 100-byte frame
      fillRamp(100, 8'h80, 8'h03);
      sendFrame(9, -1, 1'b0);

      // bad SFD: frame is dropped silently and counted bad
      repeat (7) driveByte(8'h55, 1'b1, 1'b0, 1'b1);
      driveByte(8'hD4, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) driveByte(8'(i), 1'b1, 1'b0, 1'b1);
      repeat (12) driveByte(8'h00, 1'b0, 1'b0, 1'b1);
      expBad++;
      finishFrame();

      fillRamp(64, 8'h11, 8'h05);
      sendFrame(-1, -1, 1'b0);

      // oversize: 1600 bytes, truncated at 1518
      fillRamp(1600, 8'h00, 8'h01);
      sendFrame(-1, -1, 1'b0);

      // zero-byte frame right after the SFD
      txBuf.delete();
      sendFrame(-1, -1, 1'b0);

      // enable dropped after 80 bytes of a 100-byte frame
      fillRamp(100, 8'h40, 8'h07);
      sendFrame(-1, 80, 1'b0);

      // 60 bytes plus correct FCS
      fillRamp(60, 8'h01, 8'h03);
      begin
         logic [31:0] fcs;
         fcs = refFcs(60);
         for (int k = 0; k < 4; k++) txBuf.push_back(fcs[8*k +: 8]);
      end
      sendFrame(-1, -1, 1'b0);

      // same frame with one FCS bit flipped
      txBuf[62] = txBuf[62] ^ 8'h10;
      sendFrame(-1, -1, FCS_CHECK);

      // reset in the middle of a frame: bytes already out stay, the rest vanish
      fillRamp(20, 8'hA0, 8'h01);
      repeat (7) driveByte(8'h55, 1'b1, 1'b0, 1'b1);
      driveByte(8'hD5, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         expBeat_t e;
         driveByte(txBuf[i], 1'b1, 1'b0, 1'b1);
         if (i < 18) begin
            e.data = txBuf[i];
            e.last = 1'b0;
            e.err  = 1'b0;
            e.len  = 0;
            e.cyc  = cyc + 3;
            sbQ.push_back(e);
         end
      end
      driveByte(8'h00, 1'b0, 1'b0, 1'b1);
      rstIn = 1'b1;
      repeat (2) driveByte(8'h00, 1'b0, 1'b0, 1'b1);
      rstIn = 1'b0;
      expGood = 0;
      expBad  = 0;
      repeat (6) driveByte(8'h00, 1'b0, 1'b0, 1'b1);
      finishFrame();
      check("lenAfterReset", frameLenOut, 0);

      fillRamp(70, 8'h33, 8'h0B);
      sendFrame(-1, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
